// File: rtl/alarm_siren_ctrl.sv
// Timed alarm back end: entry delay, siren burst, blinking strobe hold and sticky trip memory.
// Optional two-flop input synchronizers are enabled by defining ALARM_INPUT_SYNC_EN.
module alarm_siren_ctrl #(
   parameter int ENTRY_DELAY = 16,
   parameter int SIREN_TIME  = 64,
   parameter int BLINK_HALF  = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Alarm,
   input  logic Enable,
   input  logic Panic,
   input  logic Ack,
   output logic Siren,
   output logic Strobe,
   output logic Pending,
   output logic Tripped
);

   localparam int MAX_TIME = (ENTRY_DELAY > SIREN_TIME) ? ENTRY_DELAY : SIREN_TIME;
   localparam int CW = $clog2(MAX_TIME) + 1;
   localparam int BW = $clog2(BLINK_HALF) + 1;
   localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_DELAY - 1);
   localparam logic [CW-1:0] SIREN_LOAD = CW'(SIREN_TIME - 1);
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF - 1);

   typedef enum logic [1:0] {
      IDLE,
      ENTRY,
      SOUND,
      HOLD
   } state_t;

   logic alarmIn, enableIn, panicIn, ackIn;

`ifdef ALARM_INPUT_SYNC_EN
   logic [3:0] syncStage1_q, syncStage2_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         syncStage1_q <= '0;
         syncStage2_q <= '0;
      end else begin
         syncStage1_q <= {Alarm, Enable, Panic, Ack};
         syncStage2_q <= syncStage1_q;
      end
   end

   assign {alarmIn, enableIn, panicIn, ackIn} = syncStage2_q;
`else
   assign {alarmIn, enableIn, panicIn, ackIn} = {Alarm, Enable, Panic, Ack};
`endif

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] blinkCnt_q, blinkCnt_d;
   logic strobe_q, strobe_d;
   logic tripped_q, tripped_d;
   logic siren_q, pending_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      blinkCnt_d = blinkCnt_q;
      strobe_d   = strobe_q;
      tripped_d  = tripped_q;

      case (state_q)
         IDLE: begin
            if (panicIn) begin
               state_d = SOUND;
            end else if (alarmIn && enableIn) begin
               state_d = ENTRY;
               cnt_d   = ENTRY_LOAD;
            end
         end
         ENTRY: begin
            if (panicIn) begin
               state_d = SOUND;
            end else if (!enableIn) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = SOUND;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         SOUND: begin
            if (ackIn && !panicIn) begin
               state_d = IDLE;
            end else if (!enableIn && !panicIn) begin
               state_d = IDLE;
            end else if (panicIn) begin
               cnt_d = SIREN_LOAD;
            end else if (cnt_q == '0) begin
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         HOLD: begin
            // Panic outranks Ack; a plain alarm re-trigger does not.
            if (panicIn) begin
               state_d = SOUND;
            end else if (ackIn) begin
               state_d = IDLE;
            end else if (alarmIn && enableIn) begin
               state_d = SOUND;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == SOUND && state_q != SOUND) begin
         cnt_d = SIREN_LOAD;
      end
      if (state_d == IDLE) begin
         cnt_d = '0;
      end

      // Strobe phase restarts high on every fresh entry into SOUND and keeps running through HOLD.
      if (state_d == SOUND && state_q != SOUND) begin
         strobe_d   = 1'b1;
         blinkCnt_d = BLINK_LOAD;
      end else if (state_d == SOUND || state_d == HOLD) begin
         if (blinkCnt_q == '0) begin
            strobe_d   = ~strobe_q;
            blinkCnt_d = BLINK_LOAD;
         end else begin
            blinkCnt_d = blinkCnt_q - BW'(1);
         end
      end else begin
         strobe_d   = 1'b0;
         blinkCnt_d = '0;
      end

      if (state_d == SOUND) begin
         tripped_d = 1'b1;
      end else if (ackIn) begin
         tripped_d = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         blinkCnt_q <= '0;
         strobe_q   <= 1'b0;
         tripped_q  <= 1'b0;
         siren_q    <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         blinkCnt_q <= blinkCnt_d;
         strobe_q   <= strobe_d;
         tripped_q  <= tripped_d;
         siren_q    <= (state_d == SOUND);
         pending_q  <= (state_d == ENTRY);
      end
   end

   assign Siren   = siren_q;
   assign Strobe  = strobe_q;
   assign Pending = pending_q;
   assign Tripped = tripped_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Self-checking bench for alarm_siren_ctrl: directed scenarios plus randomized traffic
// compared against a timestamp-based behavioural model.
module tb_alarm_siren_ctrl;

   localparam int ED = 4;
   localparam int ST = 8;
   localparam int BH = 2;
   localparam int P_IDLE  = 0;
   localparam int P_ENTRY = 1;
   localparam int P_SOUND = 2;
   localparam int P_HOLD  = 3;

   logic Clock, Reset, Alarm, Enable, Panic, Ack;
   logic Siren, Strobe, Pending, Tripped;

   int total = 0;
   int bad = 0;

   // Model tracks the phase plus the edge index at which each timed interval began.
   int edgeIdx = 0;
   int mPhase = P_IDLE;
   int mEntryT = 0;
   int mSoundT = 0;
   int mBlinkT = 0;
   logic mTripped = 1'b0;

   alarm_siren_ctrl #(
      .ENTRY_DELAY(ED),
      .SIREN_TIME (ST),
      .BLINK_HALF (BH)
   ) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Alarm  (Alarm),
      .Enable (Enable),
      .Panic  (Panic),
      .Ack    (Ack),
      .Siren  (Siren),
      .Strobe (Strobe),
      .Pending(Pending),
      .Tripped(Tripped)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic void startSound(input int t);
      mPhase  = P_SOUND;
      mSoundT = t;
      mBlinkT = t;
   endfunction

   function automatic void modelEdge(input logic r, input logic a, input logic e,
                                     input logic p, input logic k);
      int t;
      edgeIdx++;
      t = edgeIdx;
      if (r) begin
         mPhase   = P_IDLE;
         mTripped = 1'b0;
      end else begin
         case (mPhase)
            P_IDLE: begin
               if (p) startSound(t);
               else if (a && e) begin
                  mPhase  = P_ENTRY;
                  mEntryT = t;
               end
            end
            P_ENTRY: begin
               if (p) startSound(t);
               else if (!e) mPhase = P_IDLE;
               else if (t - mEntryT >= ED) startSound(t);
            end
            P_SOUND: begin
               if (k && !p) mPhase = P_IDLE;
               else if (!e && !p) mPhase = P_IDLE;
               else if (p) mSoundT = t;
               else if (t - mSoundT >= ST) mPhase = P_HOLD;
            end
            default: begin
               if (p) startSound(t);
               else if (k) mPhase = P_IDLE;
               else if (a && e) startSound(t);
            end
         endcase
         if (mPhase == P_SOUND) mTripped = 1'b1;
         else if (k) mTripped = 1'b0;
      end
   endfunction

   // Expected {Siren, Strobe, Pending, Tripped} after the latest edge.
   function automatic logic [3:0] modelOut();
      logic s, st, pe;
      s  = (mPhase == P_SOUND);
      pe = (mPhase == P_ENTRY);
      st = (mPhase == P_SOUND || mPhase == P_HOLD) && ((((edgeIdx - mBlinkT) / BH) % 2) == 0);
      return {s, st, pe, mTripped};
   endfunction

   task automatic applyStimulus(input logic r, input logic a, input logic e,
                                input logic p, input logic k);
      Reset  = r;
      Alarm  = a;
      Enable = e;
      Panic  = p;
      Ack    = k;
      @(posedge Clock);
      modelEdge(r, a, e, p, k);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] got;
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 1, 0);
      got = {Siren, Strobe, Pending, Tripped};
      total++;
      if (got !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got SSPT=%b want 0000", got);
      end
   endtask

   task automatic test_entry_path();
      logic [3:0] got, exp;
      int pendCnt = 0, sirCnt = 0;
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 22; i++) begin
         applyStimulus(0, (i == 0), 1, 0, 0);
         got = {Siren, Strobe, Pending, Tripped};
         exp = modelOut();
         total++;
         if (got !== exp) begin
            bad++;
            $display("[TB] FAIL entry_path cycle %0d: got SSPT=%b want %b", i, got, exp);
         end
         pendCnt += int'(Pending);
         sirCnt  += int'(Siren);
      end
      total += 2;
      if (pendCnt != ED) begin
         bad++;
         $display("[TB] FAIL entry_pending_len: got %0d want %0d", pendCnt, ED);
      end
      if (sirCnt != ST) begin
         bad++;
         $display("[TB] FAIL entry_siren_len: got %0d want %0d", sirCnt, ST);
      end
      applyStimulus(0, 0, 1, 0, 1);
      got = {Siren, Strobe, Pending, Tripped};
      total++;
      if (got !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL entry_ack: got SSPT=%b want 0000", got);
      end
   endtask

   task automatic test_disarm_entry();
      logic [3:0] got, exp;
      int sirCnt = 0;
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 1, (i < 3), 0, 0);
         got = {Siren, Strobe, Pending, Tripped};
         exp = modelOut();
         total++;
         if (got !== exp) begin
            bad++;
            $display("[TB] FAIL disarm_entry cycle %0d: got SSPT=%b want %b", i, got, exp);
         end
         sirCnt += int'(Siren);
      end
      total++;
      if (sirCnt != 0 || Tripped !== 1'b0) begin
         bad++;
         $display("[TB] FAIL disarm_no_siren: got siren=%0d tripped=%b want 0 0", sirCnt, Tripped);
      end
   endtask

   task automatic test_panic();
      logic [3:0] got, exp;
      int sirCnt = 0, pendCnt = 0;
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0);
      total++;
      if (Siren !== 1'b1) begin
         bad++;
         $display("[TB] FAIL panic_immediate: got Siren=%b want 1", Siren);
      end
      sirCnt = int'(Siren);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         got = {Siren, Strobe, Pending, Tripped};
         exp = modelOut();
         total++;
         if (got !== exp) begin
            bad++;
            $display("[TB] FAIL panic cycle %0d: got SSPT=%b want %b", i, got, exp);
         end
         sirCnt  += int'(Siren);
         pendCnt += int'(Pending);
      end
      total++;
      if (sirCnt != ST || pendCnt != 0) begin
         bad++;
         $display("[TB] FAIL panic_len: got siren=%0d pending=%0d want %0d 0", sirCnt, pendCnt, ST);
      end
   endtask

   task automatic test_ack_panic();
      logic [3:0] got, exp;
      int sirCnt = 0;
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(0, 0, 1, (i >= 3 && i < 6), (i >= 3 && i < 6));
         got = {Siren, Strobe, Pending, Tripped};
         exp = modelOut();
         total++;
         if (got !== exp) begin
            bad++;
            $display("[TB] FAIL ack_panic cycle %0d: got SSPT=%b want %b", i, got, exp);
         end
         if (i >= 3) sirCnt += int'(Siren & Tripped);
      end
      total++;
      if (sirCnt != 8) begin
         bad++;
         $display("[TB] FAIL ack_panic_hold: got %0d siren cycles want 8", sirCnt);
      end
      applyStimulus(0, 0, 1, 0, 1);
      got = {Siren, Strobe, Pending, Tripped};
      total++;
      if (got !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL ack_panic_clear: got SSPT=%b want 0000", got);
      end
   endtask

   task automatic test_hold_retrigger();
      logic [3:0] got;
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 0);
      total++;
      if (Siren !== 1'b0 || Tripped !== 1'b1) begin
         bad++;
         $display("[TB] FAIL hold_state: got Siren=%b Tripped=%b want 0 1", Siren, Tripped);
      end
      applyStimulus(0, 1, 1, 0, 0);
      total++;
      if (Siren !== 1'b1 || Pending !== 1'b0) begin
         bad++;
         $display("[TB] FAIL hold_retrigger: got Siren=%b Pending=%b want 1 0", Siren, Pending);
      end
      applyStimulus(0, 0, 0, 0, 0);
      got = {Siren, Strobe, Pending, Tripped};
      total++;
      if (got !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL sound_disarm: got SSPT=%b want 0001", got);
      end
   endtask

   task automatic test_reset_mid_sound();
      logic [3:0] got;
      int pendCnt = 0;
      applyStimulus(0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      got = {Siren, Strobe, Pending, Tripped};
      total++;
      if (got !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_mid_sound: got SSPT=%b want 0000", got);
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, (i == 0), 1, 0, 0);
         pendCnt += int'(Pending);
      end
      total++;
      if (pendCnt != ED) begin
         bad++;
         $display("[TB] FAIL reset_restart_delay: got %0d want %0d", pendCnt, ED);
      end
   endtask

   task automatic test_random();
      logic [3:0] got, exp;
      logic r, a, e, p, k;
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 2000; i++) begin
         r = ($urandom_range(0, 127) == 0);
         a = ($urandom_range(0, 3) == 0);
         e = ($urandom_range(0, 7) != 0);
         p = ($urandom_range(0, 23) == 0);
         k = ($urandom_range(0, 11) == 0);
         applyStimulus(r, a, e, p, k);
         got = {Siren, Strobe, Pending, Tripped};
         exp = modelOut();
         total++;
         if (got !== exp) begin
            bad++;
            $display("[TB] FAIL random cycle %0d: got SSPT=%b want %b", i, got, exp);
         end
      end
   endtask

   initial begin
      Reset  = 1'b1;
      Alarm  = 1'b0;
      Enable = 1'b0;
      Panic  = 1'b0;
      Ack    = 1'b0;
      test_reset();
      test_entry_path();
      test_disarm_entry();
      test_panic();
      test_ack_panic();
      test_hold_retrigger();
      test_reset_mid_sound();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
